// File: rtl/stack_unit.sv
// LIFO stack with registered top-of-stack output and occupancy flags.
// Define STACK_UNIT_ERR_EN to enable the sticky overflow/underflow err flag.
module stack_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       err
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0] wr_en;
   logic [CW-1:0]    count_q, count_d, cnt_m1, cnt_m2;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             full_w, empty_w;

`ifdef STACK_UNIT_ERR_EN
   logic err_q, err_d;
`endif

   assign full_w  = (count_q == CW'(DEPTH));
   assign empty_w = (count_q == '0);
   assign cnt_m1  = count_q - CW'(1);
   assign cnt_m2  = count_q - CW'(2);

   always_comb begin
      wr_en   = '0;
      count_d = count_q;
      dout_d  = dout_q;
`ifdef STACK_UNIT_ERR_EN
      err_d   = err_q;
`endif
      if (push && (!pop || empty_w)) begin
         if (!full_w) begin
            wr_en[count_q[AW-1:0]] = 1'b1;
            count_d = count_q + CW'(1);
            dout_d  = din;
         end else begin
`ifdef STACK_UNIT_ERR_EN
            err_d = 1'b1;
`endif
         end
      end else if (push && pop) begin
         // Replace top in place; occupancy is unchanged.
         wr_en[cnt_m1[AW-1:0]] = 1'b1;
         dout_d = din;
      end else if (pop) begin
         if (!empty_w) begin
            count_d = cnt_m1;
            dout_d  = (count_q == CW'(1)) ? '0 : mem_q[cnt_m2[AW-1:0]];
         end else begin
`ifdef STACK_UNIT_ERR_EN
            err_d = 1'b1;
`endif
         end
      end
   end

   // Slot storage holds across reset; contents past count are don't-care.
   always_ff @(posedge clock) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_en[i]) mem_q[i] <= din;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         dout_q  <= '0;
      end else begin
         count_q <= count_d;
         dout_q  <= dout_d;
      end
   end

`ifdef STACK_UNIT_ERR_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign dout  = dout_q;
   assign count = count_q;
   assign full  = full_w;
   assign empty = empty_w;

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: a queue-based reference stack predicts each
// cycle's outputs, which are queued at drive time and compared after the edge.
module tb_stack_unit;

   localparam int W = 32;
   localparam int D = 8;
`ifdef STACK_UNIT_ERR_EN
   localparam bit ErrEn = 1'b1;
`else
   localparam bit ErrEn = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] dout;
      int           cnt;
      bit           err;
      string        tag;
   } exp_t;

   logic         clock = 1'b0;
   logic         reset;
   logic         push, pop;
   logic [W-1:0] din;
   logic [W-1:0] dout;
   logic [3:0]   count;
   logic         full, empty, err;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   logic [W-1:0] model_stk[$];
   bit           model_err;
   exp_t         sb_q[$];

   stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
      .clock(clock),
      .reset(reset),
      .push (push),
      .pop  (pop),
      .din  (din),
      .dout (dout),
      .count(count),
      .full (full),
      .empty(empty),
      .err  (err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_state(input string tag, input logic [W-1:0] e_dout, input int e_cnt,
                              input bit e_err);
      check({tag, ".dout"},  64'(dout),  64'(e_dout));
      check({tag, ".count"}, 64'(count), 64'(e_cnt));
      check({tag, ".full"},  64'(full),  64'(e_cnt == D));
      check({tag, ".empty"}, 64'(empty), 64'(e_cnt == 0));
      check({tag, ".err"},   64'(err),   64'(e_err));
   endtask

   // Drive one cycle, predict via the reference queue, compare after the edge.
   task automatic step(input string tag, input bit p, input bit q, input logic [W-1:0] d);
      exp_t e;
      push = p;
      pop  = q;
      din  = d;
      if (p && (!q || model_stk.size() == 0)) begin
         if (model_stk.size() < D) model_stk.push_back(d);
         else if (ErrEn) model_err = 1'b1;
      end else if (p && q) begin
         model_stk[model_stk.size() - 1] = d;
      end else if (q) begin
         if (model_stk.size() > 0) void'(model_stk.pop_back());
         else if (ErrEn) model_err = 1'b1;
      end
      e.dout = (model_stk.size() > 0) ? model_stk[model_stk.size() - 1] : '0;
      e.cnt  = model_stk.size();
      e.err  = model_err;
      e.tag  = tag;
      sb_q.push_back(e);
      @(posedge clock);
      #1;
      e = sb_q.pop_front();
      check_state(e.tag, e.dout, e.cnt, e.err);
      push = 1'b0;
      pop  = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      push  = 1'b0;
      pop   = 1'b0;
      din   = '0;
      model_err = 1'b0;
      #1;
      check_state("por", '0, 0, 1'b0);
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0;

      for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, W'(i));
      step("ovf", 1'b1, 1'b0, 32'd9);
      for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, '0);
      step("unf", 1'b0, 1'b1, '0);

      step("pushA", 1'b1, 1'b0, 32'hA);
      step("pushB", 1'b1, 1'b0, 32'hB);
      step("repC", 1'b1, 1'b1, 32'hC);
      step("popC", 1'b0, 1'b1, '0);
      step("popA", 1'b0, 1'b1, '0);
      step("pp_empty", 1'b1, 1'b1, 32'h5);
      step("push3a", 1'b1, 1'b0, 32'h11);
      step("push3b", 1'b1, 1'b0, 32'h22);

      // Async reset between edges with an in-flight push that must be discarded.
      push = 1'b1;
      din  = 32'hDEAD;
      #2;
      reset = 1'b1;
      #1;
      check_state("async_rst", '0, 0, 1'b0);
      @(posedge clock);
      #1;
      check_state("rst_hold", '0, 0, 1'b0);
      push = 1'b0;
      reset = 1'b0;
      model_stk.delete();
      model_err = 1'b0;

      step("post_rst", 1'b1, 1'b0, 32'h77);
      for (int i = 0; i < 300; i++) begin
         step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of stack slots (power of two, >=2).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port push  input  1  request to write din on top of stack.
REQ-006 SHALL have port pop  input  1  request to remove top of stack.
REQ-007 SHALL have port din  input  WIDTH  data to push.
REQ-008 SHALL have port dout  output  WIDTH  registered current top-of-stack word.
REQ-009 SHALL have port count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-010 SHALL have port full  output  1  high when count == DEPTH.
REQ-011 SHALL have port empty  output  1  high when count == 0.
REQ-012 SHALL have port err  output  1  sticky overflow/underflow flag (see Configuration).

Function
REQ-013 Storage SHALL be DEPTH slots of WIDTH-bit enable-gated registers; a slot SHALL load only in the cycle its write enable is asserted, and SHALL hold otherwise.
REQ-014 At most one slot write enable SHALL be asserted per cycle.
REQ-015 Push only, not full: din written to slot[count], count+1, dout = din from next cycle (latency 1).
REQ-016 Push only, full: no slot written, count unchanged, overflow event.
REQ-017 Pop only, not empty: count-1, dout = slot[count-2] next cycle, or 0 if stack becomes empty.
REQ-018 Pop only, empty: no change, underflow event.
REQ-019 Push and pop, not empty (including full): din replaces slot[count-1], count unchanged, dout = din next cycle.
REQ-020 Push and pop, empty: treated as push only; no underflow event.
REQ-021 Neither asserted: all state held.
REQ-022 dout SHALL be 0 whenever empty is high.
REQ-023 full and empty SHALL be combinational decodes of the count register, consistent with count in the same cycle.
REQ-024 Popped slot contents SHALL NOT be cleared; only count changes.

Reset
REQ-025 While reset is high, count=0, dout=0, empty=1, full=0, err=0, regardless of clock.
REQ-026 Reset asserted mid-operation SHALL discard in-flight push/pop of that cycle; slot contents are don't-care after reset.
REQ-027 First push SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro STACK_UNIT_ERR_EN SHALL select error tracking.
REQ-029 With STACK_UNIT_ERR_EN defined, err SHALL set on the edge after any overflow or underflow event and stay high until reset.
REQ-030 Without STACK_UNIT_ERR_EN, err SHALL be constant 0 and no error logic synthesized; all other behaviour identical.

Verification
REQ-031 Reset, then push 1..8 (DEPTH=8) on consecutive cycles -> count 1..8, dout follows 1..8 one cycle later, full=1 after 8th.
REQ-032 From full, push 9 -> count stays 8, dout stays 8; err=1 next cycle if STACK_UNIT_ERR_EN, else 0.
REQ-033 Pop 8 times from full -> dout 7,6,...,1,0, empty=1 after 8th; extra pop -> count 0, err=1 (ERR_EN).
REQ-034 Stack holding 0xA,0xB, push+pop with din=0xC -> count 2, dout=0xC; then pop -> dout=0xA.
REQ-035 Empty stack, push+pop with din=0x5 -> count 1, dout=0x5, err unchanged.
REQ-036 Assert reset asynchronously between edges with count=3 -> count=0, dout=0, err=0 immediately, before next edge.
